// File: rtl/bb8051_sfr_reg_pkg.sv
// bb8051 shared SFR defines: action codes,
// per-register reset values and helpers.
package bb8051_sfr_reg_pkg;

  localparam logic [2:0] BB8051_SFR_ACT_NOP     = 3'b000;
  localparam logic [2:0] BB8051_SFR_ACT_WR_BYTE = 3'b001;
  localparam logic [2:0] BB8051_SFR_ACT_WR_BIT  = 3'b010;
  localparam logic [2:0] BB8051_SFR_ACT_INC     = 3'b011;
  localparam logic [2:0] BB8051_SFR_ACT_DEC     = 3'b100;
  localparam logic [2:0] BB8051_SFR_ACT_SWAP    = 3'b101;

  localparam logic [7:0]  BB8051_RST_ACC  = 8'h00;
  localparam logic [7:0]  BB8051_RST_SP   = 8'h07;
  localparam logic [15:0] BB8051_RST_DPTR = 16'h0000;

  function automatic logic [7:0] nib_swap(
    input logic [7:0] b
  );
    return {b[3:0], b[7:4]};
  endfunction

endpackage

// File: rtl/bb8051_sfr_reg.sv
// bb8051 SFR data register (ACC/B/SP/DPTR):
// byte/bit writes, inc/dec, swap, hw write port.
module bb8051_sfr_reg
  import bb8051_sfr_reg_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int              BA_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sfr_action,
  input  logic             byte_sel,
  input  logic [BA_W-1:0]  bit_addr,
  input  logic             bit_data,
  input  logic [7:0]       wr_data,
  input  logic             hw_we,
  input  logic [WIDTH-1:0] hw_data,
  output logic [WIDTH-1:0] reg_out,
  output logic [7:0]       rd_data,
  output logic             parity,
  output logic             zero,
  output logic             wrap
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] lmask;
  logic [WIDTH-1:0] ldata;
  logic [WIDTH-1:0] bmask;
  logic             wrap_q;
  logic             wrap_nxt;
  logic             hi_sel;
  logic [3:0]       sh;
  logic             bit_ok;
  logic             is_wrb;
  logic             is_wbit;
  logic             is_inc;
  logic             is_dec;
  logic             is_swap;
  logic             is_act;
  logic             is_hw;

  // an 8-bit register has only the low lane
  assign hi_sel = (WIDTH > 8) ? byte_sel : 1'b0;
  assign sh     = hi_sel ? 4'd8 : 4'd0;
  assign lmask  = WIDTH'(8'hFF) << sh;
  assign ldata  = WIDTH'(wr_data) << sh;
  assign bmask  = WIDTH'(1) << bit_addr;
  assign bit_ok = int'(bit_addr) < WIDTH;

  assign is_wrb  = sfr_action == BB8051_SFR_ACT_WR_BYTE;
  assign is_wbit = sfr_action == BB8051_SFR_ACT_WR_BIT;
  assign is_inc  = sfr_action == BB8051_SFR_ACT_INC;
  assign is_dec  = sfr_action == BB8051_SFR_ACT_DEC;
  assign is_swap = sfr_action == BB8051_SFR_ACT_SWAP;
  assign is_act  = is_wrb | is_wbit | is_inc
                 | is_dec | is_swap;
  // software action always beats the hw port
  assign is_hw   = hw_we & ~is_act;

  // next-value mux from the current register
  always_comb begin
    nxt      = reg_q;
    wrap_nxt = 1'b0;
    unique case (1'b1)
      is_wrb:  nxt = (reg_q & ~lmask) | ldata;
      is_wbit: begin
        if (bit_ok)
          nxt = bit_data ? (reg_q | bmask)
                         : (reg_q & ~bmask);
      end
      is_inc: begin
        nxt      = reg_q + WIDTH'(1);
        wrap_nxt = &reg_q;
      end
      is_dec: begin
        nxt      = reg_q - WIDTH'(1);
        wrap_nxt = ~|reg_q;
      end
      is_swap: nxt[7:0] = nib_swap(reg_q[7:0]);
      is_hw:   nxt = hw_data;
      default: ;
    endcase
  end

  // register and wrap pulse, sync reset
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q  <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      reg_q  <= nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign reg_out = reg_q;
  assign wrap    = wrap_q;
  assign rd_data = 8'(reg_q >> sh);
  assign parity  = ^reg_q[7:0];
  assign zero    = ~|reg_q;

endmodule

// File: tb/tb_bb8051_sfr_reg.sv
// Scoreboard bench for bb8051_sfr_reg:
// 8-bit SP-style and 16-bit DPTR-style instances.
module tb_bb8051_sfr_reg;
  import bb8051_sfr_reg_pkg::*;

  localparam logic [2:0] NOP  = BB8051_SFR_ACT_NOP;
  localparam logic [2:0] WRB  = BB8051_SFR_ACT_WR_BYTE;
  localparam logic [2:0] WBIT = BB8051_SFR_ACT_WR_BIT;
  localparam logic [2:0] INC  = BB8051_SFR_ACT_INC;
  localparam logic [2:0] DEC  = BB8051_SFR_ACT_DEC;
  localparam logic [2:0] SWP  = BB8051_SFR_ACT_SWAP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, bs8, bd8, hwe8;
  logic [2:0]  act8;
  logic [3:0]  ba8;
  logic [7:0]  wd8, hwd8, ro8, rd8;
  logic        p8, z8, w8;

  logic        rst16, bs16, bd16, hwe16;
  logic [2:0]  act16;
  logic [3:0]  ba16;
  logic [7:0]  wd16, rd16;
  logic [15:0] hwd16, ro16;
  logic        p16, z16, w16;

  bb8051_sfr_reg #(
    .WIDTH(8), .RST_VAL(BB8051_RST_SP), .BA_W(4)
  ) dut8 (
    .clk(clk), .rst(rst8), .sfr_action(act8),
    .byte_sel(bs8), .bit_addr(ba8), .bit_data(bd8),
    .wr_data(wd8), .hw_we(hwe8), .hw_data(hwd8),
    .reg_out(ro8), .rd_data(rd8), .parity(p8),
    .zero(z8), .wrap(w8)
  );

  bb8051_sfr_reg #(
    .WIDTH(16), .RST_VAL(BB8051_RST_DPTR), .BA_W(4)
  ) dut16 (
    .clk(clk), .rst(rst16), .sfr_action(act16),
    .byte_sel(bs16), .bit_addr(ba16), .bit_data(bd16),
    .wr_data(wd16), .hw_we(hwe16), .hw_data(hwd16),
    .reg_out(ro16), .rd_data(rd16), .parity(p16),
    .zero(z16), .wrap(w16)
  );

  typedef struct {
    string       nm;
    int          cyc;
    bit          sel;
    logic [15:0] r;
    logic        w;
  } exp_t;

  exp_t q[$];
  int   cnt = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cnt <= cnt + 1;

  // monitor: pop every expectation due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cnt) begin
      exp_t e;
      logic [15:0] ar, er;
      logic [7:0]  ad, ed;
      logic        aw, az, ap, ez, ep;
      e = q.pop_front();
      if (e.sel) begin
        ar = ro16; ad = rd16; aw = w16;
        az = z16;  ap = p16;
        er = e.r;
        ed = bs16 ? e.r[15:8] : e.r[7:0];
      end else begin
        ar = {8'h00, ro8}; ad = rd8; aw = w8;
        az = z8;   ap = p8;
        er = {8'h00, e.r[7:0]};
        ed = e.r[7:0];
      end
      ez = (er == 16'h0000);
      ep = ^er[7:0];
      total++;
      if (ar !== er || ad !== ed || aw !== e.w
          || az !== ez || ap !== ep) begin
        bad++;
        $display("FAIL %s: got r=%h rd=%h w=%b z=%b p=%b want r=%h rd=%h w=%b z=%b p=%b",
                 e.nm, ar, ad, aw, az, ap,
                 er, ed, e.w, ez, ep);
      end
    end
  end

  task automatic idle();
    rst8 = 0; act8 = NOP; bs8 = 0; ba8 = 0;
    bd8 = 0; wd8 = 0; hwe8 = 0; hwd8 = 0;
    rst16 = 0; act16 = NOP; bs16 = 0; ba16 = 0;
    bd16 = 0; wd16 = 0; hwe16 = 0; hwd16 = 0;
  endtask

  task automatic tick(input string nm,
                      input bit sel,
                      input logic [15:0] r,
                      input logic w);
    exp_t e;
    e.nm = nm; e.cyc = cnt + 1; e.sel = sel;
    e.r = r; e.w = w;
    q.push_back(e);
    @(posedge clk);
    #2;
    idle();
  endtask

  initial begin
    idle();
    #2;
    // reset, SP-style reset value
    rst8 = 1; rst16 = 1; tick("rst0", 0, 16'h07, 0);
    rst8 = 1; rst16 = 1; tick("rst1", 0, 16'h07, 0);
    rst8 = 1; act8 = WRB; wd8 = 8'h55;
    tick("rst_wins", 0, 16'h07, 0);
    // back-to-back bit writes
    act8 = WRB; wd8 = 8'hA5; tick("wrA5", 0, 16'hA5, 0);
    act8 = WBIT; ba8 = 0; bd8 = 0;
    tick("bit0", 0, 16'hA4, 0);
    act8 = WBIT; ba8 = 7; bd8 = 0;
    tick("bit7", 0, 16'h24, 0);
    // priority over hw port
    act8 = WRB; wd8 = 8'h00; tick("wr00", 0, 16'h00, 0);
    act8 = WBIT; ba8 = 1; bd8 = 1;
    hwe8 = 1; hwd8 = 8'h3C;
    tick("prio", 0, 16'h02, 0);
    hwe8 = 1; hwd8 = 8'h3C; tick("hw", 0, 16'h3C, 0);
    // swap, out-of-range bit, unused codes
    act8 = WRB; wd8 = 8'h1E; tick("wr1E", 0, 16'h1E, 0);
    act8 = SWP; tick("swap", 0, 16'hE1, 0);
    act8 = WBIT; ba8 = 9; bd8 = 1;
    tick("bit9", 0, 16'hE1, 0);
    act8 = 3'b110; hwe8 = 1; hwd8 = 8'h5A;
    tick("c110hw", 0, 16'h5A, 0);
    act8 = 3'b111; tick("c111", 0, 16'h5A, 0);
    // 8-bit dec from zero
    act8 = WRB; wd8 = 8'h00; tick("wr00b", 0, 16'h00, 0);
    act8 = DEC; tick("dec0", 0, 16'hFF, 1);
    tick("decnop", 0, 16'hFF, 0);
    // reset in the middle of a count
    act8 = WRB; wd8 = 8'h00; tick("wr00c", 0, 16'h00, 0);
    act8 = INC; tick("inc1", 0, 16'h01, 0);
    act8 = INC; tick("inc2", 0, 16'h02, 0);
    act8 = INC; rst8 = 1; tick("incrst", 0, 16'h07, 0);
    act8 = INC; tick("inc8", 0, 16'h08, 0);
    act8 = INC; tick("inc9", 0, 16'h09, 0);
    // 16-bit lanes and wrap
    rst16 = 1; tick("r16", 1, 16'h0000, 0);
    act16 = WRB; bs16 = 1; wd16 = 8'hFF;
    tick("hiFF", 1, 16'hFF00, 0);
    act16 = WRB; bs16 = 0; wd16 = 8'hFF;
    tick("loFF", 1, 16'hFFFF, 0);
    act16 = INC; tick("inc16", 1, 16'h0000, 1);
    act16 = DEC; tick("dec16", 1, 16'hFFFF, 1);
    bs16 = 1; tick("nop16", 1, 16'hFFFF, 0);
    act16 = WBIT; ba16 = 15; bd16 = 0;
    tick("bit15", 1, 16'h7FFF, 0);
    act16 = WRB; bs16 = 0; wd16 = 8'h1E;
    tick("lo1E", 1, 16'h7F1E, 0);
    act16 = SWP; bs16 = 1; tick("swp16", 1, 16'h7FE1, 0);
    hwe16 = 1; hwd16 = 16'h1234;
    tick("hw16", 1, 16'h1234, 0);
    act16 = INC; hwe16 = 1; hwd16 = 16'hBEEF;
    tick("prio16", 1, 16'h1235, 0);
    // drain with a bound
    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
